// File: rtl/opamp_bank_ctrl.sv
// rtl/opamp_bank_ctrl.sv - op-amp bank enable/trim registers with sequential auto-zero sweep
// A Moore FSM walks the enabled channels in turn: SETTLE (break), ZERO (switch closed), RELEASE (break).
module opamp_bank_ctrl #(
  parameter int NCH    = 4,
  parameter int TRIM_W = 4,
  parameter int AZ_LEN = 8,
  parameter int PERIOD = 64,
  localparam int CHW   = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [CHW-1:0]        cfg_addr,
  input  logic [TRIM_W:0]       cfg_data,
  input  logic                  az_start,
  input  logic                  az_auto,
  output logic [NCH-1:0]        ch_en,
  output logic [NCH*TRIM_W-1:0] trim,
  output logic [NCH-1:0]        az_sw,
  output logic                  az_busy,
  output logic                  az_done
);

  localparam int AZW = (AZ_LEN > 1) ? $clog2(AZ_LEN) : 1;
  localparam int ICW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_ZERO, S_RELEASE, S_DONE} state_t;

  state_t                     r_state;
  logic [CHW-1:0]             r_ch;
  logic [AZW-1:0]             r_az_cnt;
  logic [ICW-1:0]             r_idle_cnt;
  logic [NCH-1:0]             r_en;
  logic [NCH-1:0][TRIM_W-1:0] r_trim;

  logic           w_busy;
  logic           w_wr;
  logic           w_trig;
  logic           w_any_en;
  logic           w_has_next;
  logic [CHW-1:0] w_first_ch;
  logic [CHW-1:0] w_next_ch;

  assign w_busy = (r_state == S_SETTLE) || (r_state == S_ZERO) || (r_state == S_RELEASE);
  assign w_wr   = cfg_valid && !w_busy;
  // Manual start and periodic trigger share one condition, so a coincidence starts a single sweep.
  assign w_trig = (r_state == S_IDLE) &&
                  (az_start || (az_auto && (r_idle_cnt == ICW'(PERIOD - 1))));

  always_comb begin
    w_any_en   = 1'b0;
    w_first_ch = '0;
    w_has_next = 1'b0;
    w_next_ch  = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      if (r_en[k]) begin
        w_any_en   = 1'b1;
        w_first_ch = CHW'(k);
        if (k > int'(r_ch)) begin
          w_has_next = 1'b1;
          w_next_ch  = CHW'(k);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_ch       <= '0;
      r_az_cnt   <= '0;
      r_idle_cnt <= '0;
      r_en       <= '0;
      r_trim     <= '0;
    end else begin
      for (int k = 0; k < NCH; k++) begin
        if (w_wr && (cfg_addr == CHW'(k))) begin
          r_en[k]   <= cfg_data[TRIM_W];
          r_trim[k] <= cfg_data[TRIM_W-1:0];
        end
      end
      r_idle_cnt <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_trig) begin
            r_ch    <= w_first_ch;
            r_state <= w_any_en ? S_SETTLE : S_DONE;
          end else if (az_auto) begin
            r_idle_cnt <= r_idle_cnt + 1'b1;
          end
        end
        S_SETTLE: begin
          r_az_cnt <= '0;
          r_state  <= S_ZERO;
        end
        S_ZERO: begin
          if (r_az_cnt == AZW'(AZ_LEN - 1)) begin
            r_state <= S_RELEASE;
          end else begin
            r_az_cnt <= r_az_cnt + 1'b1;
          end
        end
        S_RELEASE: begin
          if (w_has_next) begin
            r_ch    <= w_next_ch;
            r_state <= S_SETTLE;
          end else begin
            r_state <= S_DONE;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    az_sw = '0;
    ch_en = r_en;
    for (int k = 0; k < NCH; k++) begin
      if (w_busy && (r_ch == CHW'(k))) ch_en[k] = 1'b0;
      if ((r_state == S_ZERO) && (r_ch == CHW'(k))) az_sw[k] = 1'b1;
    end
  end

  assign trim      = r_trim;
  assign az_busy   = w_busy;
  assign az_done   = (r_state == S_DONE);
  assign cfg_ready = !w_busy;

endmodule

// File: tb/tb_opamp_bank_ctrl.sv
// tb/tb_opamp_bank_ctrl.sv - directed scoreboard bench for opamp_bank_ctrl
module tb_opamp_bank_ctrl;

  localparam int AZ_LEN = 8;

  typedef struct packed {
    logic        busy;
    logic        done;
    logic        ready;
    logic [3:0]  sw;
    logic [3:0]  en;
    logic [15:0] tr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [1:0]  cfg_addr;
  logic [4:0]  cfg_data;
  logic        az_start;
  logic        az_auto;
  logic [3:0]  ch_en;
  logic [15:0] trim;
  logic [3:0]  az_sw;
  logic        az_busy;
  logic        az_done;

  int          checks = 0;
  int          errors = 0;
  exp_t        sb[$];
  logic [3:0]  m_en = '0;
  logic [15:0] m_tr = '0;

  opamp_bank_ctrl dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .az_start(az_start), .az_auto(az_auto),
    .ch_en(ch_en), .trim(trim), .az_sw(az_sw), .az_busy(az_busy), .az_done(az_done)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input logic busy, input logic done, input logic [3:0] sw,
                              input logic [3:0] en, input logic [15:0] tr);
    exp_t e;
    e.busy  = busy;
    e.done  = done;
    e.ready = ~busy;
    e.sw    = sw;
    e.en    = en;
    e.tr    = tr;
    return e;
  endfunction

  function automatic exp_t obs_now();
    return {az_busy, az_done, cfg_ready, az_sw, ch_en, trim};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected per-cycle trace of one sweep over mask en, ending with the DONE cycle.
  task automatic push_sweep(input logic [3:0] en, input logic [15:0] tr);
    logic [3:0] oh;
    logic [3:0] msk;
    for (int c = 0; c < 4; c++) begin
      if (en[c]) begin
        oh  = 4'b0001 << c;
        msk = en & ~oh;
        sb.push_back(mk(1'b1, 1'b0, 4'b0000, msk, tr));
        for (int z = 0; z < AZ_LEN; z++) sb.push_back(mk(1'b1, 1'b0, oh, msk, tr));
        sb.push_back(mk(1'b1, 1'b0, 4'b0000, msk, tr));
      end
    end
    sb.push_back(mk(1'b0, 1'b1, 4'b0000, en, tr));
  endtask

  task automatic push_idle(input int n);
    for (int i = 0; i < n; i++) sb.push_back(mk(1'b0, 1'b0, 4'b0000, m_en, m_tr));
  endtask

  task automatic drain(input int n, input string tag);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (sb.size() == 0) begin
        chk({tag, " sb_underflow"}, 64'(sb.size()), 64'd1);
      end else begin
        e = sb.pop_front();
        chk($sformatf("%s c%0d", tag, i + 1), 64'(obs_now()), 64'(e));
      end
    end
  endtask

  task automatic wr(input int addr, input logic [4:0] data);
    cfg_valid = 1'b1;
    cfg_addr  = 2'(addr);
    cfg_data  = data;
    @(negedge clk);
    cfg_valid = 1'b0;
    m_en[addr]          = data[4];
    m_tr[addr*4 +: 4]   = data[3:0];
    chk($sformatf("write a%0d", addr), 64'(obs_now()), 64'(mk(1'b0, 1'b0, 4'b0000, m_en, m_tr)));
  endtask

  initial begin
    cfg_valid = 1'b0;
    cfg_addr  = '0;
    cfg_data  = '0;
    az_start  = 1'b0;
    az_auto   = 1'b0;
    rst       = 1'b0;
    #1 rst = 1'b1;
    #1 chk("reset_async", 64'(obs_now()), 64'(mk(1'b0, 1'b0, 4'b0000, 4'b0000, 16'h0000)));
    @(negedge clk);
    rst = 1'b0;

    wr(2, 5'b11010);
    chk("ch2_trim", 64'(trim[11:8]), 64'(4'b1010));
    wr(3, 5'b00111);
    chk("ch3_disabled", 64'(ch_en[3]), 64'd0);
    wr(0, 5'b10011);

    az_start = 1'b1;
    push_sweep(m_en, m_tr);
    push_idle(1);
    drain(1, "sweep02");
    az_start = 1'b0;
    drain(sb.size(), "sweep02");

    az_start = 1'b1;
    push_sweep(m_en, m_tr);
    drain(1, "busywr");
    az_start  = 1'b0;
    cfg_valid = 1'b1;
    cfg_addr  = 2'd1;
    cfg_data  = 5'b11111;
    drain(4, "busywr");
    az_start = 1'b1;
    drain(1, "busywr");
    az_start = 1'b0;
    drain(15, "busywr");
    az_start = 1'b1;
    m_en[1]    = 1'b1;
    m_tr[7:4]  = 4'b1111;
    push_idle(2);
    drain(1, "busywr_post");
    az_start  = 1'b0;
    cfg_valid = 1'b0;
    drain(1, "busywr_post");
    chk("busywr_sb_empty", 64'(sb.size()), 64'd0);

    wr(0, 5'b00000);
    wr(1, 5'b00000);
    wr(2, 5'b00000);
    az_start = 1'b1;
    push_sweep(m_en, m_tr);
    push_idle(1);
    drain(1, "noen");
    az_start = 1'b0;
    drain(sb.size(), "noen");

    wr(1, 5'b10110);
    az_auto = 1'b1;
    push_idle(63);
    push_sweep(m_en, m_tr);
    push_idle(64);
    sb.push_back(mk(1'b1, 1'b0, 4'b0000, 4'b0000, m_tr));
    for (int z = 0; z < 4; z++) sb.push_back(mk(1'b1, 1'b0, 4'b0010, 4'b0000, m_tr));
    drain(sb.size(), "auto");
    chk("auto_in_zero", 64'(az_sw), 64'(4'b0010));
    #2 rst = 1'b1;
    az_auto = 1'b0;
    m_en = '0;
    m_tr = '0;
    #1 chk("rst_mid_zero", 64'(obs_now()), 64'(mk(1'b0, 1'b0, 4'b0000, 4'b0000, 16'h0000)));
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk($sformatf("rst_hold%0d", i), 64'(obs_now()), 64'(mk(1'b0, 1'b0, 4'b0000, 4'b0000, 16'h0000)));
    end
    rst = 1'b0;
    push_idle(3);
    drain(3, "post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/opamp_bank_ctrl.md
OPAMP_BANK_CTRL -- requirements
Module: opamp_bank_ctrl

Interface
REQ-001 Parameter NCH, default 4, number of op-amp channels controlled.
REQ-002 Parameter TRIM_W, default 4, offset-trim code width per channel.
REQ-003 Parameter AZ_LEN, default 8, auto-zero switch-closed duration in clk cycles (>=1).
REQ-004 Parameter PERIOD, default 64, idle cycles between automatic sweeps (>=1).
REQ-005 The block SHALL have exactly one clock and one reset, with the ports listed below.
REQ-006 clk  in  1  sole clock; all state updates on the rising edge.
REQ-007 rst  in  1  reset; asynchronous and active-high.
REQ-008 cfg_valid  in  1  configuration write request.
REQ-009 cfg_ready  out  1  configuration write may be accepted.
REQ-010 cfg_addr  in  max(1,clog2(NCH))  target channel index.
REQ-011 cfg_data  in  TRIM_W+1  bit TRIM_W is the enable bit; bits TRIM_W-1:0 are the trim code.
REQ-012 az_start  in  1  requests one auto-zero sweep.
REQ-013 az_auto  in  1  level; enables periodic sweeps.
REQ-014 ch_en  out  NCH  per-channel output-connect enable.
REQ-015 trim  out  NCH*TRIM_W  channel k trim code is at trim[k*TRIM_W +: TRIM_W].
REQ-016 az_sw  out  NCH  auto-zero switch drive; at most one bit is high (one-hot or zero).
REQ-017 az_busy  out  1  sweep in progress.
REQ-018 az_done  out  1  one-cycle pulse at sweep end.

Function
REQ-019 A write SHALL occur when cfg_valid && cfg_ready; en_reg[addr] and trim_reg[addr] update at that edge.
REQ-020 A write with cfg_addr>=NCH SHALL be accepted with no effect.
REQ-021 cfg_ready SHALL equal ~az_busy.
REQ-022 trim SHALL be driven directly from trim_reg.
REQ-023 ch_en[k] SHALL equal en_reg[k], except that it is 0 while channel k is in SETTLE, ZERO or RELEASE.
REQ-024 The FSM SHALL have the states IDLE, SETTLE, ZERO, RELEASE and DONE; all outputs are registered or decoded from state (Moore).
REQ-025 IDLE->SETTLE SHALL occur on az_start, or on az_auto with idle counter == PERIOD-1, if at least one en_reg bit is set; ch = lowest enabled index.
REQ-026 IDLE->DONE SHALL occur on the same trigger as REQ-025 when no channel is enabled.
REQ-027 SETTLE SHALL last 1 cycle with az_sw=0 (break-before-make), then go to ZERO.
REQ-028 ZERO SHALL last AZ_LEN cycles with az_sw[ch]=1, then go to RELEASE.
REQ-029 RELEASE SHALL last 1 cycle with az_sw=0; it then goes to SETTLE at the next higher enabled channel, else to DONE.
REQ-030 DONE SHALL last 1 cycle with az_done=1 and az_busy=0, then go to IDLE.
REQ-031 az_busy SHALL be 1 exactly in SETTLE, ZERO and RELEASE; a sweep of m enabled channels keeps busy high for m*(AZ_LEN+2) cycles.
REQ-032 Disabled channels SHALL be skipped with zero cycles spent on them.
REQ-033 az_start asserted while az_busy=1 or in DONE SHALL be ignored (not queued).
REQ-034 The idle counter SHALL count IDLE cycles while az_auto=1, clear on leaving IDLE or when az_auto=0, and saturate at no point other than triggering at PERIOD-1.
REQ-035 When az_start and the periodic trigger coincide, exactly one sweep SHALL start.
REQ-036 The ZERO-duration counter SHALL reload per channel; no cycle SHALL be lost or duplicated on channel transitions.

Reset
REQ-037 While rst=1, the block SHALL clear immediately: ch_en=0, trim=0, az_sw=0, az_busy=0, az_done=0, en_reg=0, trim_reg=0, counters=0, state=IDLE.
REQ-038 cfg_ready SHALL be 1 during and after reset.
REQ-039 Reset asserted mid-sweep SHALL abort the sweep with no az_done pulse.

Verification (NCH=4, TRIM_W=4, AZ_LEN=8, PERIOD=64)
REQ-040 Assert rst -> all outputs 0, cfg_ready=1, asynchronously, without waiting for a clk edge.
REQ-041 Write addr=2, data=5'b11010 -> next cycle ch_en=4'b0100 and trim[11:8]=4'b1010; a write to addr 3 with data 5'b0xxxx leaves ch_en[3]=0.
REQ-042 Enable ch0 and ch2, then pulse az_start at edge 0:
  - az_busy is high for 20 cycles.
  - az_sw=0001 for cycles 2-9 and az_sw=0100 for cycles 12-19.
  - ch_en[0] is low for cycles 1-10 and ch_en[2] is low for cycles 11-20.
  - az_done pulses in cycle 21.
REQ-043 During a sweep, hold cfg_valid high and pulse az_start -> cfg_ready=0, no register change, no second sweep; the pending write is accepted in the DONE cycle.
REQ-044 No channel enabled, pulse az_start -> az_busy stays 0, az_done pulses in the next cycle, and az_sw stays 0.
REQ-045 Enable ch1 with az_auto=1 -> sweeps start every 64 IDLE cycles; asserting rst mid-ZERO drives az_sw to 0 at once, with no az_done pulse.
